// File: rtl/fetch_pc_unit.sv
// Instruction fetch and program counter stage.
// Fetches one word per instruction and computes next pc on retire.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned FETCH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  input  logic        jr,
  input  logic [31:0] rs_data,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_err,
  output logic        misalign,
  output logic [31:0] retire_cnt
);

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } state_t;

  localparam logic [15:0] TMAX = 16'(FETCH_TIMEOUT - 1);

  state_t      state;
  logic [15:0] tcnt;
  logic [31:0] next_pc;
  logic [31:0] br_off;

  assign imem_addr = pc;
  assign op        = instr[31:26];
  assign funct     = instr[5:0];
  assign pc_plus4  = pc + 32'd4;

  // Next pc selection: jr over jump over taken branch over fall-through.
  always_comb begin
    br_off  = {{14{instr[15]}}, instr[15:0], 2'b00};
    next_pc = pc_plus4;
    if (jr)
      next_pc = {rs_data[31:2], 2'b00};
    else if (jump)
      next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
    else if (branch && zero)
      next_pc = pc_plus4 + br_off;
  end

  // Fetch/exec sequencer; req gap after timeout, ack wins at expiry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      fetch_err   <= 1'b0;
      misalign    <= 1'b0;
      retire_cnt  <= '0;
      tcnt        <= '0;
    end else begin
      fetch_err <= 1'b0;
      misalign  <= 1'b0;
      unique case (state)
        FETCH: begin
          if (!imem_req) begin
            imem_req <= 1'b1;
          end else if (imem_ack) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            tcnt        <= '0;
            state       <= EXEC;
          end else if (tcnt == TMAX) begin
            fetch_err <= 1'b1;
            imem_req  <= 1'b0;
            tcnt      <= '0;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        EXEC: begin
          if (instr_ready) begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            retire_cnt  <= retire_cnt + 32'd1;
            misalign    <= jr && (rs_data[1:0] != 2'b00);
            tcnt        <= '0;
            state       <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit.
// Drives and samples on the falling edge.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch;
  logic        zero;
  logic        jump;
  logic        jr;
  logic [31:0] rs_data;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_err;
  logic        misalign;
  logic [31:0] retire_cnt;

  int errors = 0;
  int checks = 0;

  fetch_pc_unit #(
    .RESET_PC     (32'h0000_0000),
    .FETCH_TIMEOUT(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .op         (op),
    .funct      (funct),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .branch     (branch),
    .zero       (zero),
    .jump       (jump),
    .jr         (jr),
    .rs_data    (rs_data),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .fetch_err  (fetch_err),
    .misalign   (misalign),
    .retire_cnt (retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Wait for req, hold off w cycles, then ack one cycle.
  task automatic fetch(input logic [31:0] word, input int w);
    int n;
    n = 0;
    while (!imem_req && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", {31'd0, imem_req}, 32'd1);
    repeat (w) @(negedge clk);
    imem_ack   = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    chk("valid_after_ack", {31'd0, instr_valid}, 32'd1);
  endtask

  task automatic retire(input logic b, input logic z,
                        input logic j, input logic r,
                        input logic [31:0] rs);
    instr_ready = 1'b1;
    branch      = b;
    zero        = z;
    jump        = j;
    jr          = r;
    rs_data     = rs;
    @(negedge clk);
    instr_ready = 1'b0;
    branch      = 1'b0;
    zero        = 1'b0;
    jump        = 1'b0;
    jr          = 1'b0;
    rs_data     = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic bad;
    rst = 1'b1;
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    instr_ready = 1'b0;
    branch = 1'b0;
    zero = 1'b0;
    jump = 1'b0;
    jr = 1'b0;
    rs_data = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_cnt", retire_cnt, 32'h0);
    chk("rst_instr", instr, 32'h0);

    // 1: first fetch
    rst = 1'b0;
    @(negedge clk);
    chk("req_after_rst", {31'd0, imem_req}, 32'd1);
    chk("addr0", imem_addr, 32'h0);
    fetch(32'h2008_0005, 1);
    chk("op", {26'd0, op}, 32'h08);
    chk("funct", {26'd0, funct}, 32'h05);
    chk("pc0", pc, 32'h0);
    chk("req_low_exec", {31'd0, imem_req}, 32'd0);

    // 2: sequential
    retire(0, 0, 0, 0, 0);
    chk("seq_pc4", pc, 32'h4);
    chk("seq_req", {31'd0, imem_req}, 32'd1);
    chk("seq_addr", imem_addr, 32'h4);
    fetch(32'h0, 0);
    retire(0, 0, 0, 0, 0);
    chk("seq_pc8", pc, 32'h8);
    fetch(32'h0, 0);
    retire(0, 0, 0, 0, 0);
    chk("seq_pcC", pc, 32'hC);
    chk("seq_cnt3", retire_cnt, 32'd3);

    // 3: branch taken / not taken at 0x40
    fetch(32'h0800_0010, 0);
    retire(0, 0, 1, 0, 0);
    chk("j_to_40", pc, 32'h40);
    fetch(32'h1000_FFFE, 0);
    chk("beq_op", {26'd0, op}, 32'h04);
    retire(1, 1, 0, 0, 0);
    chk("beq_taken", pc, 32'h3C);
    fetch(32'h0800_0010, 0);
    retire(0, 0, 1, 0, 0);
    chk("j_back_40", pc, 32'h40);
    fetch(32'h1000_FFFE, 0);
    retire(1, 0, 0, 0, 0);
    chk("beq_not_taken", pc, 32'h44);

    // 4: jump region, then jr over jump with misaligned target
    fetch(32'h0000_0000, 0);
    retire(0, 0, 0, 1, 32'h1000_0010);
    chk("jr_aligned", pc, 32'h1000_0010);
    chk("no_misalign", {31'd0, misalign}, 32'd0);
    fetch(32'h0800_0100, 0);
    retire(0, 0, 1, 0, 0);
    chk("jump_region", pc, 32'h1000_0400);
    fetch(32'h0800_0100, 0);
    retire(0, 0, 1, 1, 32'h0000_0203);
    chk("jr_prio", pc, 32'h200);
    chk("misalign_hi", {31'd0, misalign}, 32'd1);

    // 5: timeout with no ack
    bad = 1'b0;
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      if (i == 1) chk("misalign_pulse", {31'd0, misalign}, 32'd0);
      if (!imem_req || fetch_err) bad = 1'b1;
    end
    chk("wait_window", {31'd0, bad}, 32'd0);
    @(negedge clk);
    chk("fetch_err_hi", {31'd0, fetch_err}, 32'd1);
    chk("req_gap", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    chk("fetch_err_pulse", {31'd0, fetch_err}, 32'd0);
    chk("reissue_req", {31'd0, imem_req}, 32'd1);
    chk("reissue_addr", imem_addr, 32'h200);
    fetch(32'h0000_0020, 15);
    chk("ack_wins_err", {31'd0, fetch_err}, 32'd0);
    chk("ack_wins_instr", instr, 32'h0000_0020);

    // 6: reset in EXEC, late ack ignored, pc wrap
    rst = 1'b1;
    @(negedge clk);
    chk("rst_exec_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_exec_pc", pc, 32'h0);
    chk("rst_exec_cnt", retire_cnt, 32'h0);
    rst = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 32'h1234_5678;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("late_ack_valid", {31'd0, instr_valid}, 32'd0);
    chk("late_ack_req", {31'd0, imem_req}, 32'd1);
    fetch(32'h0, 0);
    retire(0, 0, 0, 1, 32'hFFFF_FFFC);
    chk("pc_top", pc, 32'hFFFF_FFFC);
    chk("pc4_wrap", pc_plus4, 32'h0);
    fetch(32'h0, 0);
    retire(0, 0, 0, 0, 0);
    chk("pc_wrap", pc, 32'h0);
    chk("cnt_after_rst", retire_cnt, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
